// File: rtl/pwm_peripheral.sv
// -----------------------------------------------------------------------------
// pwm_peripheral
//
// Output stage for the SPI register file. Each of the 16 chip outputs is
// forced low, forced high, or driven by one shared 8-bit PWM waveform,
// depending on its output-enable and PWM-select bits.
//
// Datapath: clock prescaler (divide by CLK_DIV) -> 8-bit period counter ->
// unsigned compare against the active duty -> per-bit mux -> output register.
//
// Parameters:
//   CLK_DIV          prescaler ratio, 1..255; PWM period = CLK_DIV*256 clocks
//
// Ports:
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   en_reg_out_7_0   output enables, out[7:0]
//   en_reg_out_15_8  output enables, out[15:8]
//   en_reg_pwm_7_0   PWM select, out[7:0]
//   en_reg_pwm_15_8  PWM select, out[15:8]
//   pwm_duty_cycle   duty, high time = duty/256 of the period, 0xFF = 100%
//   out              registered chip outputs
//
// Build option:
//   PWM_DUTY_SHADOW_EN  when defined, the duty is captured into a shadow
//                       register only on the period-boundary cycle, so each
//                       period runs with one consistent duty value. When not
//                       defined, the duty input is used live.
// -----------------------------------------------------------------------------
`timescale 1ns / 1ps

module pwm_peripheral #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out
);

  localparam logic [7:0] PreMax = 8'(CLK_DIV - 1);

  logic [7:0]  pre_cnt_q, pre_cnt_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [15:0] out_q, out_d;
  logic        tick;
  logic        boundary;
  logic [7:0]  duty_act;
  logic        pwm_sig;
  logic [15:0] en_out;
  logic [15:0] en_pwm;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // NOTE: every combinational output gets a value on every path (here, by
  // plain unconditional assignment or a full ternary), so no latch is inferred.
  always_comb begin
    tick      = (pre_cnt_q == PreMax);
    boundary  = tick && (pwm_cnt_q == 8'hFF);
    pre_cnt_d = tick ? 8'd0 : pre_cnt_q + 8'd1;
    // The period counter wraps 255 -> 0 by natural 8-bit overflow.
    pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
  end

`ifdef PWM_DUTY_SHADOW_EN
  logic [7:0] duty_q, duty_d;

  // Loading on the boundary cycle makes the new duty valid exactly when the
  // counter reads 0, so a period never mixes two duty values.
  always_comb begin
    duty_d   = boundary ? pwm_duty_cycle : duty_q;
    duty_act = duty_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= 8'd0;
    end else begin
      duty_q <= duty_d;
    end
  end
`else
  always_comb begin
    duty_act = pwm_duty_cycle;
  end

  // The boundary strobe only feeds the shadow register.
  logic unused_boundary;
  assign unused_boundary = boundary;
`endif

  // 0xFF is special-cased to a constant 1: a plain "cnt < 255" compare would
  // drop low for one counter step at cnt == 255.
  always_comb begin
    pwm_sig = (duty_act == 8'hFF) || (pwm_cnt_q < duty_act);
    // en_out dominates; en_pwm only chooses between constant 1 and the PWM.
    out_d   = en_out & (~en_pwm | {16{pwm_sig}});
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= 8'd0;
      pwm_cnt_q <= 8'd0;
      out_q     <= 16'h0000;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      out_q     <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// -----------------------------------------------------------------------------
// tb_pwm_peripheral
//
// Self-checking bench for pwm_peripheral (CLK_DIV = 13). A reference model
// derives the expected outputs from the number of clock edges since reset:
// state index s gives pwm_cnt = (s / CLK_DIV) % 256, and the output after an
// edge reflects the state and inputs just before it. Inputs are changed only
// on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns / 1ps

module tb_pwm_peripheral;

  localparam int D = 13;
  localparam int P = D * 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] en_out = '0;
  logic [15:0] en_pwm = '0;
  logic [7:0]  duty = '0;
  logic [15:0] out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pwm_peripheral #(.CLK_DIV(D)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (out)
  );

  // ---------------- reference model ----------------
  int          k;        // clock edges since reset release
  logic [7:0]  shadow;   // duty in force for the current period (shadow build)
  logic [15:0] exp_out;

  function automatic logic [15:0] expect_out(input int s, input logic [7:0] d,
                                             input logic [15:0] eo,
                                             input logic [15:0] ep);
    logic hi;
    hi = (d == 8'hFF) || (((s / D) % 256) < int'(d));
    return eo & (~ep | {16{hi}});
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k       <= 0;
      shadow  <= 8'h00;
      exp_out <= 16'h0000;
    end else begin
`ifdef PWM_DUTY_SHADOW_EN
      exp_out <= expect_out(k, shadow, en_out, en_pwm);
      if (k % P == P - 1) shadow <= duty;
`else
      exp_out <= expect_out(k, duty, en_out, en_pwm);
`endif
      k <= k + 1;
    end
  end

  // Runs n cycles, counting model mismatches and high samples of one bit.
  task automatic run(input int n, input int bit_i, output int mism, output int hi);
    mism = 0;
    hi   = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (out !== exp_out) mism++;
      if (out[bit_i] === 1'b1) hi++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int m, h;
    logic [15:0] first_exp;
`ifdef PWM_DUTY_SHADOW_EN
    first_exp = 16'h0000;
    h = 0;
`else
    first_exp = 16'hFFFF;
`endif
    rst_n = 1'b0; en_out = 16'hFFFF; en_pwm = 16'hFFFF; duty = 8'h80;
    repeat (5) @(negedge clk);
    tests++;
    if (out !== 16'h0000) begin
      fails++; $display("FAIL reset_hold: out=%h expected=%h", out, 16'h0000);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (out !== first_exp) begin
      fails++; $display("FAIL reset_first_edge: out=%h expected=%h", out, first_exp);
    end
    run(700, 0, m, h);
    tests++;
    if (m != 0) begin
      fails++; $display("FAIL reset_run: mismatching cycles=%0d expected=0", m);
    end
    // Asynchronous reset in the middle of the period, away from any edge.
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if (out !== 16'h0000) begin
      fails++; $display("FAIL reset_async: out=%h expected=%h", out, 16'h0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run(700, 0, m, h);
    tests++;
`ifdef PWM_DUTY_SHADOW_EN
    if (m != 0 || h != 0) begin
      fails++; $display("FAIL reset_restart: mism=%0d high=%0d expected 0/0", m, h);
    end
`else
    // States 0..699 are all below 0x80*13, so bit 0 must be high throughout.
    if (m != 0 || h != 700) begin
      fails++; $display("FAIL reset_restart: mism=%0d high=%0d expected 0/700", m, h);
    end
`endif
  endtask

  task automatic test_static();
    int bad;
    en_out = 16'hA5A5; en_pwm = 16'h0000; duty = 8'h37;
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out !== 16'hA5A5) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL static_a5a5: bad cycles=%0d last out=%h expected=%h", bad, out, 16'hA5A5);
    end
    en_out = 16'h0000; en_pwm = 16'hFFFF;
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out !== 16'h0000) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL static_pwm_only: bad cycles=%0d last out=%h expected=%h", bad, out, 16'h0000);
    end
  endtask

  task automatic test_duty50();
    int m, h, hi_run, lo_run;
    logic prev;
    bit found;
    en_out = 16'hFFFF; en_pwm = 16'hFFFF; duty = 8'h80;
    run(P, 0, m, h);
    tests++;
    if (m != 0) begin
      fails++; $display("FAIL duty50_settle: mismatching cycles=%0d expected=0", m);
    end
    prev  = out[0];
    found = 1'b0;
    for (int i = 0; i < P + 10 && !found; i++) begin
      @(negedge clk);
      if (!prev && out[0]) found = 1'b1;
      prev = out[0];
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL duty50_rise: rising edge seen=0 expected=1");
    end else begin
      hi_run = 1;
      for (int i = 0; i < P && out[0] === 1'b1; i++) begin
        @(negedge clk);
        if (out[0] === 1'b1) hi_run++;
      end
      lo_run = 1;
      for (int i = 0; i < P && out[0] === 1'b0; i++) begin
        @(negedge clk);
        if (out[0] === 1'b0) lo_run++;
      end
      tests++;
      if (hi_run != 1664) begin
        fails++; $display("FAIL duty50_high: high clocks=%0d expected=1664", hi_run);
      end
      tests++;
      if (lo_run != 1664 || hi_run + lo_run != P) begin
        fails++; $display("FAIL duty50_period: low=%0d period=%0d expected 1664/%0d", lo_run, hi_run + lo_run, P);
      end
    end
    run(P, 15, m, h);
    tests++;
    if (m != 0 || h != 1664) begin
      fails++; $display("FAIL duty50_allbits: mism=%0d bit15 high=%0d expected 0/1664", m, h);
    end
  endtask

  task automatic test_extremes();
    logic [7:0] duties [3];
    int periods [3];
    int m, h;
    duties  = '{8'h00, 8'hFF, 8'h01};
    periods = '{3, 1, 1};
    en_out = 16'hFFFF; en_pwm = 16'hFFFF;
    for (int t = 0; t < 3; t++) begin
      duty = duties[t];
      run(P, 0, m, h);
      run(periods[t] * P, 0, m, h);
      tests++;
      if (m != 0 || h != periods[t] * int'(duties[t] == 8'hFF ? P : D * int'(duties[t]))) begin
        fails++;
        $display("FAIL extreme_duty_%h: mism=%0d high=%0d expected 0/%0d", duties[t], m, h,
                 periods[t] * int'(duties[t] == 8'hFF ? P : D * int'(duties[t])));
      end
    end
  endtask

  task automatic test_mid_change();
    int m, h, h1, exp_h1;
`ifdef PWM_DUTY_SHADOW_EN
    exp_h1 = 832;
`else
    exp_h1 = 2496;
`endif
    en_out = 16'hFFFF; en_pwm = 16'hFFFF; duty = 8'h40;
    run(P, 0, m, h);
    for (int i = 0; i < P && (k % P) != 0; i++) @(negedge clk);
    tests++;
    if ((k % P) != 0) begin
      fails++; $display("FAIL mid_align: phase=%0d expected=0", k % P);
    end
    h1 = 0;
    m  = 0;
    for (int i = 0; i < P; i++) begin
      if ((k % P) == 16 * D) duty = 8'hC0;
      @(negedge clk);
      if (out !== exp_out) m++;
      if (out[0] === 1'b1) h1++;
    end
    tests++;
    if (m != 0 || h1 != exp_h1) begin
      fails++; $display("FAIL mid_current: mism=%0d high=%0d expected 0/%0d", m, h1, exp_h1);
    end
    run(P, 0, m, h);
    tests++;
    if (m != 0 || h != 2496) begin
      fails++; $display("FAIL mid_next: mism=%0d high=%0d expected 0/2496", m, h);
    end
  endtask

  task automatic test_random();
    int m, h;
    for (int r = 0; r < 8; r++) begin
      en_out = 16'($urandom);
      en_pwm = 16'($urandom);
      case (r)
        0:       duty = 8'h00;
        1:       duty = 8'hFF;
        default: duty = 8'($urandom);
      endcase
      run(int'($urandom_range(300, 1200)), 0, m, h);
      tests++;
      if (m != 0) begin
        fails++;
        $display("FAIL random_%0d: mism=%0d en_out=%h en_pwm=%h duty=%h expected 0", r, m, en_out, en_pwm, duty);
      end
    end
  endtask

  task automatic test_mixed();
    int m, h;
    int h0, h4, h8;
    en_out = 16'h00FF; en_pwm = 16'h000F; duty = 8'h80;
    run(P, 0, m, h);
    m = 0; h0 = 0; h4 = 0; h8 = 0;
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      if (out !== exp_out) m++;
      if (out[0] === 1'b1) h0++;
      if (out[7:4] === 4'hF) h4++;
      if (out[15:8] !== 8'h00) h8++;
    end
    tests++;
    if (m != 0 || h0 != 1664 || h4 != P || h8 != 0) begin
      fails++;
      $display("FAIL mixed_mux: mism=%0d bit0 high=%0d bits7:4 high=%0d bits15:8 nonzero=%0d expected 0/1664/%0d/0",
               m, h0, h4, h8, P);
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_duty50();
    test_extremes();
    test_mid_change();
    test_random();
    test_mixed();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
